alu_cmd_sequencer: RTL
======================

# alu_cmd_sequencer

Parametrised command sequencer between the UART receiver/transmitter and the ALU. It collects a frame of operand A (`DATA_W/8` bytes), one ASCII operator byte, and operand B (`DATA_W/8` bytes). It decodes the operator to an ALU opcode, presents stable operands to the combinational ALU, captures the result and streams it back byte-serially through the UART transmitter. It replaces the fixed 8-bit interface with width-generic operands, explicit handshakes, error reporting and an optional inter-byte timeout.

## Interface
Parameters:
- `DATA_W`, 8: operand/result width; multiple of 8, range 8..64. `NB = DATA_W/8`.
- `OP_W`, 6: ALU opcode width.
- `TIMEOUT_CYC`, 1_000_000: inter-byte timeout in clk cycles; only used with `ALU_SEQ_TIMEOUT_EN`.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `rx_data`, in, 8: received byte; valid in the cycle `rx_done` is high.
- `rx_done`, in, 1: one-cycle pulse per received byte.
- `tx_done`, in, 1: one-cycle pulse when the transmitter finishes a byte. The transmitter is idle after reset.
- `alu_result`, in, DATA_W: combinational ALU output.
- `alu_a`, `alu_b`, out, DATA_W: ALU operands, registered.
- `alu_op`, out, OP_W: ALU opcode, registered.
- `tx_data`, out, 8: byte to transmit, registered.
- `tx_start`, out, 1: one-cycle start pulse to the transmitter.
- `busy`, out, 1: high in S_EXEC, S_TX, S_TXW.
- `err`, out, 1: high from an invalid-operator commit until the next frame's first byte is accepted.

## Operation
- Reset value of all outputs is 0. State is S_A, and all byte indices are 0.
- States:
  - S_A: accept NB bytes into the A shadow register, LSB first; go to S_OP.
  - S_OP: accept one byte and decode it via the opcode table; go to S_B.
  - S_B: accept NB bytes into the B shadow register, LSB first; on the last byte go to S_EXEC.
  - S_EXEC: one cycle; latch `alu_result` into the TX shift register; go to S_TX.
  - S_TX: drive `tx_data` = the current result byte (LSB first) and pulse `tx_start`; go to S_TXW.
  - S_TXW: wait for `tx_done`. On `tx_done`, go to S_TX if bytes remain, otherwise go to S_A.
- Commit on the last B byte:
  - Valid operator: `alu_a`, `alu_b` and `alu_op` load from the shadows together. They hold until the next commit.
  - Invalid operator: the ALU outputs are not updated. `err` is set, and the transmission is a single byte `ERR_BYTE` = 8'hEE instead of NB result bytes.
- `rx_done` in S_EXEC, S_TX or S_TXW is ignored and the byte is dropped. `tx_done` outside S_TXW is ignored.
- Opcode table:
  - '+' → 6'b100000, '-' → 6'b100010, '&' → 6'b100100, '|' → 6'b100101
  - '^' → 6'b100110, '~' → 6'b100111, 'a' → 6'b000011, 'l' → 6'b000010
  - Any other byte is invalid.
- Reset mid-operation discards the frame and any pending transmission immediately. No further `tx_start` is issued.

## Timing
- `rx_done` for the last B byte sampled at edge t:
  - `alu_*` valid after edge t+1 (state S_EXEC).
  - Result latched at edge t+2.
  - `tx_start` and `tx_data` high/valid in the cycle after edge t+3.
- `tx_start` is exactly one cycle wide. `tx_data` is held stable from `tx_start` until the matching `tx_done`.
- The next `tx_start` is asserted 2 cycles after the `tx_done` that precedes it.
- A new frame is accepted starting in the cycle after the final `tx_done`. `rx_done` in that same cycle is ignored.
- The ALU is combinational. `alu_result` is sampled exactly one cycle after the operands update.

## Configuration
- `ALU_SEQ_TIMEOUT_EN` defined:
  - A down-counter reloads to `TIMEOUT_CYC` on every accepted byte and counts only in a partial frame (S_A with index>0, S_OP, S_B).
  - On reaching 0, the state returns to S_A, indices clear and shadows are discarded. Outputs are unchanged and `err` is not set.
  - `rx_done` in the expiry cycle takes priority: the byte is accepted and the counter reloads.
- Undefined: no counter logic; a partial frame waits indefinitely.

## Structure
- Package `alu_seq_pkg` holds:
  - opcode localparams and the ASCII operator constants;
  - `ERR_BYTE`;
  - the state encoding (S_A, S_OP, S_B, S_EXEC, S_TX, S_TXW).
- Sub-module `ascii_opcode_decode` is purely combinational: 8-bit ASCII in; `OP_W` opcode and `valid` out.

## Test plan
- DATA_W=8, bytes 0x05,'-',0x07 with a reference ALU → `alu_a`=0x05, `alu_b`=0x07, `alu_op`=6'b100010; one `tx_start` with `tx_data`=0xFE.
- DATA_W=16, bytes 0x34,0x12,'+',0x01,0x01 → `alu_a`=0x1234, `alu_b`=0x0101; TX bytes 0x35 then 0x13, two `tx_start` pulses, each gated by `tx_done`.
- DATA_W=8, bytes 0x01,'?',0x02 → `err`=1, single TX byte 0xEE, `alu_*` unchanged. The next valid frame's first byte clears `err`.
- `rx_done` pulses during S_TX/S_TXW → bytes dropped. The next frame 0x03,'&',0x06 yields TX 0x02.
- `reset` asserted while in S_TXW → all outputs 0 asynchronously; no `tx_start` after release. A new frame then works.
- With `ALU_SEQ_TIMEOUT_EN`, `TIMEOUT_CYC`=100: send 0x09, idle 101 cycles, then frame 0x02,'|',0x04 → TX 0x06. Repeat with 99 idle cycles → frame continues (0x09 is A).

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU command sequencer: ALU opcodes, ASCII
// operator characters, the error reply byte and the sequencer states.
package alu_seq_pkg;

  localparam logic [5:0] OPC_ADD = 6'b100000;
  localparam logic [5:0] OPC_SUB = 6'b100010;
  localparam logic [5:0] OPC_AND = 6'b100100;
  localparam logic [5:0] OPC_OR  = 6'b100101;
  localparam logic [5:0] OPC_XOR = 6'b100110;
  localparam logic [5:0] OPC_NOR = 6'b100111;
  localparam logic [5:0] OPC_SRA = 6'b000011;
  localparam logic [5:0] OPC_SRL = 6'b000010;

  localparam logic [7:0] ASC_ADD = 8'h2B; // '+'
  localparam logic [7:0] ASC_SUB = 8'h2D; // '-'
  localparam logic [7:0] ASC_AND = 8'h26; // '&'
  localparam logic [7:0] ASC_OR  = 8'h7C; // '|'
  localparam logic [7:0] ASC_XOR = 8'h5E; // '^'
  localparam logic [7:0] ASC_NOR = 8'h7E; // '~'
  localparam logic [7:0] ASC_SRA = 8'h61; // 'a'
  localparam logic [7:0] ASC_SRL = 8'h6C; // 'l'

  // Single reply byte sent instead of a result when the operator is unknown
  localparam logic [7:0] ERR_BYTE = 8'hEE;

  typedef enum logic [2:0] {
    S_A,
    S_OP,
    S_B,
    S_EXEC,
    S_TX,
    S_TXW
  } seq_state_e;

endpackage

// File: rtl/ascii_opcode_decode.sv
// Combinational ASCII operator to ALU opcode decoder; valid=0 for any
// character outside the operator table.
module ascii_opcode_decode
  import alu_seq_pkg::*;
#(
  parameter int unsigned OP_W = 6
) (
  input  logic [7:0]      ascii,
  output logic [OP_W-1:0] opcode,
  output logic            valid
);

  // Table lookup of the operator character
  always_comb begin
    opcode = '0;
    valid  = 1'b1;
    case (ascii)
      ASC_ADD: opcode = OP_W'(OPC_ADD);
      ASC_SUB: opcode = OP_W'(OPC_SUB);
      ASC_AND: opcode = OP_W'(OPC_AND);
      ASC_OR:  opcode = OP_W'(OPC_OR);
      ASC_XOR: opcode = OP_W'(OPC_XOR);
      ASC_NOR: opcode = OP_W'(OPC_NOR);
      ASC_SRA: opcode = OP_W'(OPC_SRA);
      ASC_SRL: opcode = OP_W'(OPC_SRL);
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer between UART RX/TX and a combinational ALU.
// Collects A (NB bytes, LSB first), an ASCII operator, B (NB bytes),
// commits operands to the ALU, then streams the result back byte-serially.
// Optional inter-byte timeout: define ALU_SEQ_TIMEOUT_EN.
module alu_cmd_sequencer #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned OP_W        = 6,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  input  logic              tx_done,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic              busy,
  output logic              err
);

  import alu_seq_pkg::*;

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned IDX_W = $clog2(NB + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);
  localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(NB);

  seq_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] a_sh_q, a_sh_d;
  logic [DATA_W-1:0] b_sh_q, b_sh_d;
  logic [OP_W-1:0]   op_sh_q, op_sh_d;
  logic              opv_q, opv_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [IDX_W-1:0]  tx_left_q, tx_left_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;

  logic [OP_W-1:0]   dec_op;
  logic              dec_valid;

  ascii_opcode_decode #(.OP_W(OP_W)) u_decode (
    .ascii  (rx_data),
    .opcode (dec_op),
    .valid  (dec_valid)
  );

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             partial, rx_acc, tmo_hit;

  // Inter-byte watchdog: reload on every accepted byte, count down only mid-frame
  always_comb begin
    partial = ((state_q == S_A) && (idx_q != '0)) || (state_q == S_OP) ||
              ((state_q == S_B) && (idx_q != IDX_FULL));
    rx_acc  = rx_done && ((state_q == S_A) || (state_q == S_OP) ||
              ((state_q == S_B) && (idx_q != IDX_FULL)));
    tmo_hit = partial && !rx_done && (tmo_q == '0);
    tmo_d   = tmo_q;
    if (rx_acc) begin
      tmo_d = TMO_W'(TIMEOUT_CYC);
    end else if (partial && (tmo_q != '0)) begin
      tmo_d = tmo_q - 1'b1;
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_A;
      idx_q      <= '0;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      op_sh_q    <= '0;
      opv_q      <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      err_q      <= 1'b0;
      tx_sh_q    <= '0;
      tx_left_q  <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      op_sh_q    <= op_sh_d;
      opv_q      <= opv_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      err_q      <= err_d;
      tx_sh_q    <= tx_sh_d;
      tx_left_q  <= tx_left_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  // Next-state logic; S_B lingers one cycle after the last byte so the
  // commit lands on the following edge and the ALU has a full cycle to settle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_A:    if (rx_done && (idx_q == IDX_LAST)) state_d = S_OP;
      S_OP:   if (rx_done) state_d = S_B;
      S_B:    if (idx_q == IDX_FULL) state_d = S_EXEC;
      S_EXEC: state_d = S_TX;
      S_TX:   state_d = S_TXW;
      S_TXW:  if (tx_done) state_d = (tx_left_q == '0) ? S_A : S_TX;
      default: state_d = S_A;
    endcase
`ifdef ALU_SEQ_TIMEOUT_EN
    if (tmo_hit) state_d = S_A;
`endif
  end

  // Byte collection, commit, result capture and TX byte sequencing
  always_comb begin
    idx_d      = idx_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    op_sh_d    = op_sh_q;
    opv_d      = opv_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    err_d      = err_q;
    tx_sh_d    = tx_sh_q;
    tx_left_d  = tx_left_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    case (state_q)
      S_A: begin
        if (rx_done) begin
          for (int unsigned i = 0; i < NB; i++) begin
            if (idx_q == IDX_W'(i)) a_sh_d[i*8 +: 8] = rx_data;
          end
          if (idx_q == '0) err_d = 1'b0;
          idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
      end
      S_OP: begin
        if (rx_done) begin
          op_sh_d = dec_op;
          opv_d   = dec_valid;
        end
      end
      S_B: begin
        if (idx_q == IDX_FULL) begin
          idx_d = '0;
          if (opv_q) begin
            alu_a_d  = a_sh_q;
            alu_b_d  = b_sh_q;
            alu_op_d = op_sh_q;
          end else begin
            err_d = 1'b1;
          end
        end else if (rx_done) begin
          for (int unsigned i = 0; i < NB; i++) begin
            if (idx_q == IDX_W'(i)) b_sh_d[i*8 +: 8] = rx_data;
          end
          idx_d = idx_q + 1'b1;
        end
      end
      S_EXEC: begin
        tx_sh_d   = opv_q ? alu_result : DATA_W'(ERR_BYTE);
        tx_left_d = opv_q ? IDX_FULL : IDX_W'(1);
      end
      S_TX: begin
        tx_data_d  = tx_sh_q[7:0];
        tx_start_d = 1'b1;
        tx_sh_d    = tx_sh_q >> 8;
        tx_left_d  = tx_left_q - 1'b1;
      end
      default: ;
    endcase
`ifdef ALU_SEQ_TIMEOUT_EN
    if (tmo_hit) begin
      idx_d   = '0;
      a_sh_d  = '0;
      b_sh_d  = '0;
      op_sh_d = '0;
      opv_d   = 1'b0;
    end
`endif
  end

  // Output drive
  always_comb begin
    alu_a    = alu_a_q;
    alu_b    = alu_b_q;
    alu_op   = alu_op_q;
    tx_data  = tx_data_q;
    tx_start = tx_start_q;
    err      = err_q;
    busy     = (state_q == S_EXEC) || (state_q == S_TX) || (state_q == S_TXW);
  end

endmodule
